// File: rtl/rocc_router.sv
// rtl/rocc_router.sv - RoCC command router to NrAcc accelerators with round-robin response return
// Optional per-channel watchdog: define ROCC_ROUTER_TIMEOUT_EN.
module rocc_router #(
    parameter int unsigned NrAcc          = 2,
    parameter int unsigned CmdW           = 160,
    parameter int unsigned RespW          = 69,
    parameter int unsigned SelLsb         = 7,
    parameter int unsigned RdLsb          = 12,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned WakeCycles     = 16,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CmdW-1:0]          cmd_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    output logic [RespW-1:0]         resp_o,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [NrAcc*CmdW-1:0]    acc_cmd_o,
    output logic [NrAcc-1:0]         acc_cmd_valid_o,
    input  logic [NrAcc-1:0]         acc_cmd_ready_i,
    input  logic [NrAcc*RespW-1:0]   acc_resp_i,
    input  logic [NrAcc-1:0]         acc_resp_valid_i,
    output logic [NrAcc-1:0]         acc_resp_ready_o,
    output logic                     busy_o,
    output logic                     awake_o,
    output logic [NrAcc-1:0]         err_o
);

    localparam int unsigned SelW  = (NrAcc > 1) ? $clog2(NrAcc) : 1;
    localparam int unsigned NrReq = NrAcc + 1;
    localparam int unsigned PtrW  = $clog2(NrReq);
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
    localparam int unsigned WakeW = (WakeCycles > 0) ? $clog2(WakeCycles + 1) : 1;
    localparam logic [CntW-1:0]  MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [WakeW-1:0] WakeEnd = WakeW'(WakeCycles);
    localparam logic [PtrW-1:0]  ErrIdx  = PtrW'(NrAcc);

    logic [WakeW-1:0] wake_cnt;
    logic             awake;
    logic [CntW-1:0]  cnt [NrAcc];
    logic [NrAcc-1:0] has_room;
    logic [NrAcc-1:0] cmd_fire;
    logic [NrAcc-1:0] resp_fire;
    logic [SelW-1:0]  sel;
    logic             sel_hit;
    logic             err_load;
    logic             err_take;
    logic             err_valid;
    logic [4:0]       err_rd;
    logic [NrReq-1:0] req;
    logic [PtrW-1:0]  ptr;
    logic [PtrW-1:0]  grant_idx;
    logic             grant_valid;
    logic             resp_load;
    logic             resp_take;
    logic [RespW-1:0] grant_data;
    logic [RespW-1:0] resp_q;
    logic             resp_valid_q;
    logic             any_outstanding;

    // Requester index (base + off) modulo NrReq; the error slot is the last requester.
    function automatic logic [PtrW-1:0] rr_next(input logic [PtrW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NrReq) s = s - NrReq;
        return PtrW'(s);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wake_cnt <= '0;
        end else if (wake_cnt != WakeEnd) begin
            wake_cnt <= wake_cnt + 1'b1;
        end
    end

    assign awake   = (wake_cnt == WakeEnd);
    assign awake_o = awake;

    assign acc_cmd_o = {NrAcc{cmd_i}};
    assign sel       = cmd_i[SelLsb +: SelW];

    always_comb begin
        for (int k = 0; k < NrAcc; k++) begin
            has_room[k] = (cnt[k] < MaxCnt);
        end
    end

    // Command valid never waits on ready; selects beyond NrAcc go to the local error slot.
    always_comb begin
        acc_cmd_valid_o = '0;
        cmd_fire        = '0;
        sel_hit         = 1'b0;
        cmd_ready_o     = 1'b0;
        for (int k = 0; k < NrAcc; k++) begin
            if (sel == SelW'(k)) begin
                sel_hit            = 1'b1;
                acc_cmd_valid_o[k] = cmd_valid_i & awake & has_room[k];
                cmd_ready_o        = awake & acc_cmd_ready_i[k] & has_room[k];
                cmd_fire[k]        = cmd_valid_i & awake & acc_cmd_ready_i[k] & has_room[k];
            end
        end
        if (!sel_hit) begin
            cmd_ready_o = awake & !err_valid;
        end
    end

    assign err_load = cmd_valid_i & !sel_hit & awake & !err_valid;

    assign req = {err_valid, acc_resp_valid_i};

    // Scan downward so the requester closest to the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = int'(NrReq) - 1; i >= 0; i--) begin
            if (req[rr_next(ptr, i)]) begin
                grant_valid = 1'b1;
                grant_idx   = rr_next(ptr, i);
            end
        end
    end

    always_comb begin
        grant_data = RespW'({err_rd, {64{1'b1}}});
        for (int k = 0; k < NrAcc; k++) begin
            if (grant_idx == PtrW'(k)) begin
                grant_data = acc_resp_i[k*RespW +: RespW];
            end
        end
    end

    assign resp_load = !resp_valid_q | resp_ready_i;
    assign resp_take = resp_load & grant_valid;
    assign err_take  = resp_take & (grant_idx == ErrIdx);

    always_comb begin
        for (int k = 0; k < NrAcc; k++) begin
            resp_fire[k] = resp_take & (grant_idx == PtrW'(k));
        end
    end

    assign acc_resp_ready_o = resp_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            ptr          <= '0;
            err_valid    <= 1'b0;
            err_rd       <= '0;
        end else begin
            if (resp_take) begin
                resp_valid_q <= 1'b1;
                resp_q       <= grant_data;
                ptr          <= rr_next(grant_idx, 1);
            end else if (resp_ready_i) begin
                resp_valid_q <= 1'b0;
            end
            if (err_load) begin
                err_valid <= 1'b1;
                err_rd    <= cmd_i[RdLsb +: 5];
            end else if (err_take) begin
                err_valid <= 1'b0;
            end
        end
    end

    assign resp_o       = resp_q;
    assign resp_valid_o = resp_valid_q;

    // A response with nothing outstanding is still forwarded; the count just stays at zero.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrAcc; k++) begin
            if (rst_i) begin
                cnt[k] <= '0;
            end else if (cmd_fire[k] && !resp_fire[k]) begin
                cnt[k] <= cnt[k] + 1'b1;
            end else if (!cmd_fire[k] && resp_fire[k] && (cnt[k] != '0)) begin
                cnt[k] <= cnt[k] - 1'b1;
            end
        end
    end

    always_comb begin
        any_outstanding = 1'b0;
        for (int k = 0; k < NrAcc; k++) begin
            any_outstanding = any_outstanding | (cnt[k] != '0);
        end
    end

    assign busy_o = any_outstanding | resp_valid_q | err_valid;

`ifdef ROCC_ROUTER_TIMEOUT_EN
    localparam int unsigned      WdW   = $clog2(TimeoutCycles + 1);
    localparam logic [WdW-1:0]   WdEnd = WdW'(TimeoutCycles);

    logic [WdW-1:0]   wd [NrAcc];
    logic [NrAcc-1:0] err_q;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NrAcc; k++) begin
            if (rst_i) begin
                wd[k]    <= '0;
                err_q[k] <= 1'b0;
            end else begin
                if ((cnt[k] == '0) || resp_fire[k]) begin
                    wd[k] <= '0;
                end else if (wd[k] != WdEnd) begin
                    wd[k] <= wd[k] + 1'b1;
                end
                if (wd[k] == WdEnd) begin
                    err_q[k] <= 1'b1;
                end
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = '0;
`endif

endmodule

// File: tb/tb_rocc_router.sv
// tb/tb_rocc_router.sv - directed self-checking bench for rocc_router (NrAcc=3)
module tb_rocc_router;

    localparam int NrAcc = 3;
    localparam int CmdW  = 160;
    localparam int RespW = 69;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [CmdW-1:0]        cmd_i;
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic [RespW-1:0]       resp_o;
    logic                   resp_valid_o;
    logic                   resp_ready_i;
    logic [NrAcc*CmdW-1:0]  acc_cmd_o;
    logic [NrAcc-1:0]       acc_cmd_valid_o;
    logic [NrAcc-1:0]       acc_cmd_ready_i;
    logic [NrAcc*RespW-1:0] acc_resp_i;
    logic [NrAcc-1:0]       acc_resp_valid_i;
    logic [NrAcc-1:0]       acc_resp_ready_o;
    logic                   busy_o;
    logic                   awake_o;
    logic [NrAcc-1:0]       err_o;

    int n_checks = 0;
    int n_fail   = 0;

    rocc_router #(
        .NrAcc(NrAcc), .CmdW(CmdW), .RespW(RespW), .SelLsb(7), .RdLsb(12),
        .MaxOutstanding(4), .WakeCycles(16), .TimeoutCycles(1024)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .resp_o(resp_o), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .acc_cmd_o(acc_cmd_o), .acc_cmd_valid_o(acc_cmd_valid_o), .acc_cmd_ready_i(acc_cmd_ready_i),
        .acc_resp_i(acc_resp_i), .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
        .busy_o(busy_o), .awake_o(awake_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [CmdW-1:0] make_cmd(input logic [1:0] sel, input logic [4:0] rd);
        logic [CmdW-1:0] c;
        c          = '0;
        c[159:128] = 32'hDEAD_BEEF;
        c[7 +: 2]  = sel;
        c[12 +: 5] = rd;
        return c;
    endfunction

    initial begin
        rst_i            = 1'b1;
        cmd_i            = make_cmd(2'd1, 5'd9);
        cmd_valid_i      = 1'b1;
        resp_ready_i     = 1'b0;
        acc_cmd_ready_i  = 3'b010;
        acc_resp_i       = '0;
        acc_resp_valid_i = '0;
        step();
        step();

        check_eq("rst_resp_valid", resp_valid_o, 0);
        check_eq("rst_resp", resp_o, 0);
        check_eq("rst_cmd_ready", cmd_ready_o, 0);
        check_eq("rst_acc_valid", acc_cmd_valid_o, 0);
        check_eq("rst_acc_resp_ready", acc_resp_ready_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_awake", awake_o, 0);
        check_eq("rst_err", err_o, 0);

        // Wake-up: cycles 0..15 refuse the held command, cycle 16 accepts it.
        rst_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("wake_ready_c%0d", i), cmd_ready_o, 0);
            check_eq($sformatf("wake_awake_c%0d", i), awake_o, 0);
            if (i == 15) check_eq("wake_acc_valid", acc_cmd_valid_o, 0);
            step();
        end
        check_eq("awake_c16", awake_o, 1);
        check_eq("ready_c16", cmd_ready_o, 1);
        check_eq("acc_valid_sel1", acc_cmd_valid_o, 3'b010);
        check_eq("acc_cmd_bcast", acc_cmd_o[1*CmdW +: CmdW] == cmd_i, 1);
        step();
        cmd_valid_i = 1'b0;
        #1;
        check_eq("busy_after_cmd", busy_o, 1);

        // Single response from ch1 with one cycle latency and held under backpressure.
        acc_resp_i[1*RespW +: RespW] = {5'd5, 64'h1234};
        acc_resp_valid_i             = 3'b010;
        #1;
        check_eq("ch1_resp_ready", acc_resp_ready_o, 3'b010);
        check_eq("resp_valid_pre", resp_valid_o, 0);
        step();
        acc_resp_valid_i = '0;
        #1;
        check_eq("ch1_resp_valid", resp_valid_o, 1);
        check_eq("ch1_resp", resp_o, {5'd5, 64'h1234});
        step();
        check_eq("ch1_resp_hold", resp_o, {5'd5, 64'h1234});
        check_eq("ch1_busy_pending", busy_o, 1);
        resp_ready_i = 1'b1;
        step();
        check_eq("ch1_popped", resp_valid_o, 0);
        check_eq("ch1_idle", busy_o, 0);

        // Outstanding limit on ch0: four accepted, fifth waits for one response.
        cmd_i           = make_cmd(2'd0, 5'd1);
        cmd_valid_i     = 1'b1;
        acc_cmd_ready_i = 3'b001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("lim_ready_%0d", i), cmd_ready_o, 1);
            step();
        end
        check_eq("lim_stall_ready", cmd_ready_o, 0);
        check_eq("lim_stall_valid", acc_cmd_valid_o, 0);
        step();
        check_eq("lim_stall_ready2", cmd_ready_o, 0);
        acc_resp_i[0*RespW +: RespW] = {5'd1, 64'hA0};
        acc_resp_valid_i             = 3'b001;
        #1;
        check_eq("lim_resp_ready", acc_resp_ready_o, 3'b001);
        check_eq("lim_ready_same", cmd_ready_o, 0);
        step();
        acc_resp_valid_i = '0;
        #1;
        check_eq("lim_resp", resp_o, {5'd1, 64'hA0});
        check_eq("lim_ready_freed", cmd_ready_o, 1);
        step();
        cmd_valid_i      = 1'b0;
        acc_resp_valid_i = 3'b001;
        for (int i = 0; i < 4; i++) step();
        acc_resp_valid_i = '0;
        step();
        check_eq("lim_drained_valid", resp_valid_o, 0);
        check_eq("lim_drained_busy", busy_o, 0);

        // Out-of-range select answered locally.
        cmd_i           = make_cmd(2'd3, 5'd7);
        cmd_valid_i     = 1'b1;
        acc_cmd_ready_i = 3'b111;
        #1;
        check_eq("oor_ready", cmd_ready_o, 1);
        check_eq("oor_no_acc_valid", acc_cmd_valid_o, 0);
        step();
        check_eq("oor_slot_full_ready", cmd_ready_o, 0);
        check_eq("oor_busy", busy_o, 1);
        check_eq("oor_no_acc_ready", acc_resp_ready_o, 0);
        step();
        cmd_valid_i = 1'b0;
        #1;
        check_eq("oor_resp_valid", resp_valid_o, 1);
        check_eq("oor_resp", resp_o, {5'd7, 64'hFFFF_FFFF_FFFF_FFFF});
        step();
        check_eq("oor_idle", busy_o, 0);

        // Pointer is back at 0: ch0/ch1 alternate with no bubbles.
        acc_resp_i[0*RespW +: RespW] = {5'd2, 64'hC0};
        acc_resp_i[1*RespW +: RespW] = {5'd3, 64'hC1};
        acc_resp_valid_i             = 3'b011;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_grant_%0d", i), acc_resp_ready_o, (i % 2 == 0) ? 3'b001 : 3'b010);
            step();
            check_eq($sformatf("rr_valid_%0d", i), resp_valid_o, 1);
            check_eq($sformatf("rr_data_%0d", i), resp_o,
                     (i % 2 == 0) ? {5'd2, 64'hC0} : {5'd3, 64'hC1});
        end
        resp_ready_i = 1'b0;
        #1;
        check_eq("rr_backpressure", acc_resp_ready_o, 0);
        step();
        check_eq("rr_hold", resp_o, {5'd3, 64'hC1});
        acc_resp_valid_i = '0;
        resp_ready_i     = 1'b1;
        step();
        check_eq("rr_sat_idle", busy_o, 0);

        // Reset mid-operation discards state and restarts the wake delay.
        cmd_i       = make_cmd(2'd2, 5'd4);
        cmd_valid_i = 1'b1;
        step();
        check_eq("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        step();
        check_eq("mid_rst_busy", busy_o, 0);
        check_eq("mid_rst_awake", awake_o, 0);
        check_eq("mid_rst_ready", cmd_ready_o, 0);
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check_eq("mid_rewake", awake_o, 1);

        // Watchdog on an unanswered ch1 command.
        cmd_i       = make_cmd(2'd1, 5'd6);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
`ifdef ROCC_ROUTER_TIMEOUT_EN
        for (int i = 0; i < 1000; i++) step();
        check_eq("wd_before", err_o, 0);
        for (int i = 0; i < 40; i++) step();
        check_eq("wd_fired", err_o, 3'b010);
        acc_resp_i[1*RespW +: RespW] = {5'd6, 64'h1};
        acc_resp_valid_i             = 3'b010;
        step();
        acc_resp_valid_i = '0;
        step();
        check_eq("wd_sticky", err_o, 3'b010);
        rst_i = 1'b1;
        step();
        check_eq("wd_cleared", err_o, 0);
        rst_i = 1'b0;
`else
        for (int i = 0; i < 40; i++) step();
        check_eq("wd_absent", err_o, 0);
        check_eq("wd_outstanding", busy_o, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
